if_id_buf: RTL
==============

Name: if_id_buf

Overview:
- Two-entry elastic buffer between the fetch stage and the decode stage.
- Captures the fetched PC, the instruction and the predict-taken flag, and presents them to decode with a valid/ready handshake.
- Decouples fetch from decode stalls.
- Supports a pipeline flush from execute on a branch mispredict.

Parameters:
- PC_W, 32, PC width (matches `PC_WIDTH).
- INSTR_W, 32, instruction width (matches `INSTR_WIDTH).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush from execute; discards all buffered entries.
- if_valid_i  in  1  fetch presents a valid instruction.
- if_ready_o  out  1  buffer can accept an entry.
- if_pc_i  in  PC_W  PC of the fetched instruction.
- if_instr_i  in  INSTR_W  fetched instruction.
- if_prdt_taken_i  in  1  fetch predicted taken.
- id_valid_o  out  1  head entry valid toward decode.
- id_ready_i  in  1  decode accepts the head entry.
- id_pc_o  out  PC_W  head PC.
- id_instr_o  out  INSTR_W  head instruction.
- id_prdt_taken_o  out  1  head prediction flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (rst_i). Everything is registered on the rising edge of clk_i.
- Storage:
  - 2 entries {pc, instr, prdt_taken}.
  - 1-bit write pointer wptr and read pointer rptr.
  - 2-bit count cnt, range 0..2.
- Reset: cnt=0, wptr=0, rptr=0, all entry fields=0.
  - Outputs at reset: id_valid_o=0, if_ready_o=1, id_pc_o=0, id_instr_o=0, id_prdt_taken_o=0.
- Handshakes:
  - push = if_valid_i & if_ready_o.
  - pop = id_valid_o & id_ready_i.
- Ready and valid:
  - if_ready_o = (cnt != 2). It is a function of state only; there is no combinational path from id_ready_i.
  - id_valid_o = (cnt != 0).
- Head outputs: id_pc_o, id_instr_o and id_prdt_taken_o come from entry[rptr]. Their value while id_valid_o=0 is don't-care to consumers, but it is the stale entry content, never X.
- Push: write entry[wptr], wptr toggles, cnt+1.
- Pop: rptr toggles, cnt-1.
- Push and pop in the same cycle: both pointers toggle and cnt is unchanged. This is legal only at cnt=1 (cnt=0 has no pop; cnt=2 has no push).
- Latency: without bypass, an entry pushed in cycle N is visible on the id_* outputs in cycle N+1.
- Throughput: 1 per cycle sustained when decode is always ready.
- Flush:
  - When flush_i=1 at a clock edge: cnt=0, wptr=0, rptr=0.
  - Any push or pop in that cycle is discarded.
  - id_valid_o=0 in the following cycle.
  - Entry data is not cleared.
- Full: while cnt=2, if_ready_o=0 and fetch must hold its inputs stable.
- Empty: while cnt=0, id_valid_o=0 and id_ready_i is ignored.
- Reset mid-operation: asynchronous return to the reset state regardless of the handshakes in progress.
- Pointer wrap: each 1-bit pointer wraps naturally from 1 to 0.

Optional Feature:
- Macro: IF_ID_BYPASS_EN.
- Defined:
  - When cnt=0 and flush_i=0: id_valid_o=if_valid_i, and the id_* data outputs are driven combinationally from the if_* inputs.
  - If id_ready_i=1 in that cycle, the entry is consumed without being written: no pointer or cnt change.
  - Otherwise it is written as a normal push.
  - Result: zero-cycle latency when empty. if_ready_o is unchanged (cnt != 2).
- Not defined: behaviour exactly as above; 1-cycle minimum latency and no input-to-output combinational paths.

Decomposition:
- Shared defines header (defines.v):
  - Existing `PC_WIDTH and `INSTR_WIDTH.
  - Add `IF_ID_DEPTH=2 for documentation only.
- Entry storage and the read mux stay in this module.
- One sub-module is natural: if_id_ctrl, holding the pointer/count state and the ready/valid generation.

Test Plan:
1. Reset then idle: rst_i=1, then 0 -> if_ready_o=1, id_valid_o=0, id_pc_o=0.
2. Streaming with id_ready_i=1: push pc=0x80000000/0x80000004/0x80000008 back-to-back -> id_pc_o shows the same PCs one cycle later each. cnt never exceeds 1.
3. Backpressure with id_ready_i=0: push pc=0x100, 0x104 -> if_ready_o=0 after the second push. A third request with pc=0x108 is held. Raise id_ready_i -> outputs 0x100, then 0x104, then 0x108, in order.
4. Flush when full: cnt=2, assert flush_i with if_valid_i=1 and pc=0x200 -> next cycle id_valid_o=0, if_ready_o=1, and 0x200 is never delivered.
5. Prediction flag: push instr=0xFE000EE3 with prdt_taken=1 -> id_prdt_taken_o=1 and id_instr_o=0xFE000EE3 with that entry.
6. Async reset mid-stream: assert rst_i between clock edges with cnt=2 -> id_valid_o=0 immediately, without waiting for a clock edge.
   - Additionally with IF_ID_BYPASS_EN: empty buffer, if_valid_i=1, pc=0x300, id_ready_i=1 -> id_valid_o=1 and id_pc_o=0x300 in the same cycle; cnt stays 0.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// Shared widths and count helpers for the fetch/decode elastic buffer.
// Optional zero-latency bypass is enabled by defining IF_ID_BYPASS_EN.
package if_id_buf_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;
    localparam int IF_ID_DEPTH = 2;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_EMPTY = 2'd0;
    localparam cnt_t CNT_FULL  = 2'd2;

    // Simultaneous push and pop leaves the occupancy unchanged
    function automatic cnt_t next_cnt(input cnt_t cnt, input logic push, input logic pop);
        cnt_t result;
        result = cnt;
        if (push && !pop)
            result = cnt + 2'd1;
        else if (pop && !push)
            result = cnt - 2'd1;
        return result;
    endfunction

endpackage

// File: rtl/if_id_ctrl.sv
// Pointer/count state and ready/valid generation for the IF/ID buffer.
// IF_ID_BYPASS_EN adds an empty-buffer pass-through of the fetch handshake.
module if_id_ctrl
    import if_id_buf_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic if_valid_i,
    input  logic id_ready_i,
    output logic if_ready_o,
    output logic id_valid_o,
    output logic wr_en_o,
`ifdef IF_ID_BYPASS_EN
    output logic bypass_o,
`endif
    output logic wptr_o,
    output logic rptr_o
);

    cnt_t cnt;
    logic wptr;
    logic rptr;
    logic buf_valid;
    logic push;
    logic pop;

    // Ready depends only on occupancy so decode stalls never reach fetch combinationally
    always_comb begin
        if_ready_o = (cnt != CNT_FULL);
        buf_valid  = (cnt != CNT_EMPTY);
        push       = if_valid_i & if_ready_o;
        pop        = buf_valid & id_ready_i;
`ifdef IF_ID_BYPASS_EN
        bypass_o   = (cnt == CNT_EMPTY) & ~flush_i;
        id_valid_o = bypass_o ? if_valid_i : buf_valid;
        wr_en_o    = push & ~flush_i & ~(bypass_o & id_ready_i);
`else
        id_valid_o = buf_valid;
        wr_en_o    = push & ~flush_i;
`endif
    end

    // Flush wins over any handshake in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt  <= CNT_EMPTY;
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else if (flush_i) begin
            cnt  <= CNT_EMPTY;
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            cnt <= next_cnt(cnt, wr_en_o, pop);
            if (wr_en_o)
                wptr <= ~wptr;
            if (pop)
                rptr <= ~rptr;
        end
    end

    assign wptr_o = wptr;
    assign rptr_o = rptr;

endmodule

// File: rtl/if_id_buf.sv
// Two-entry elastic buffer carrying {pc, instr, prdt_taken} from fetch to decode.
// Define IF_ID_BYPASS_EN for zero-cycle latency when the buffer is empty.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int PC_W    = PC_WIDTH,
    parameter int INSTR_W = INSTR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               if_valid_i,
    output logic               if_ready_o,
    input  logic [PC_W-1:0]    if_pc_i,
    input  logic [INSTR_W-1:0] if_instr_i,
    input  logic               if_prdt_taken_i,
    output logic               id_valid_o,
    input  logic               id_ready_i,
    output logic [PC_W-1:0]    id_pc_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic               id_prdt_taken_o
);

    logic [PC_W-1:0]    pc_q    [IF_ID_DEPTH];
    logic [INSTR_W-1:0] instr_q [IF_ID_DEPTH];
    logic               prdt_q  [IF_ID_DEPTH];
    logic               wr_en;
    logic               wptr;
    logic               rptr;
`ifdef IF_ID_BYPASS_EN
    logic               bypass;
`endif

    if_id_ctrl u_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .id_ready_i (id_ready_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .wr_en_o    (wr_en),
`ifdef IF_ID_BYPASS_EN
        .bypass_o   (bypass),
`endif
        .wptr_o     (wptr),
        .rptr_o     (rptr)
    );

    // Entry data is cleared only by reset; a flush just rewinds the pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < IF_ID_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                prdt_q[i]  <= 1'b0;
            end
        end else if (wr_en) begin
            pc_q[wptr]    <= if_pc_i;
            instr_q[wptr] <= if_instr_i;
            prdt_q[wptr]  <= if_prdt_taken_i;
        end
    end

    always_comb begin
        id_pc_o         = pc_q[rptr];
        id_instr_o      = instr_q[rptr];
        id_prdt_taken_o = prdt_q[rptr];
`ifdef IF_ID_BYPASS_EN
        if (bypass) begin
            id_pc_o         = if_pc_i;
            id_instr_o      = if_instr_i;
            id_prdt_taken_o = if_prdt_taken_i;
        end
`endif
    end

endmodule
